// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MAX_WAIT_DEF  = 16;
  localparam int unsigned BURST_LEN_DEF = 8;

  typedef enum logic [1:0] {
    S_CPU,
    S_LDR,
    S_FORCE
  } arb_state_e;

  // $clog2 that never yields a zero-width vector (e.g. for a limit of 1).
  function automatic int unsigned clog2_min1(input int unsigned v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between CPU MEM stage, UART loader, DataMem and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface dmem_bus_arbiter_if;
  import dmem_arb_pkg::*;

  logic              cpu_rd;
  logic              cpu_wr;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [DATA_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              grant_ldr;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, ldr_ack, ldr_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, grant_ldr
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, ldr_ack, ldr_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, grant_ldr
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Clear/increment counter flagging when it sits at its terminal value.
// Clear wins over increment; callers never increment past TERM.
module arb_wait_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TERM  = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Count register, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = count_q + WIDTH'(1);
  end

  assign term_o = (count_q == WIDTH'(TERM));

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Arbitrates the single DataMem port between the CPU MEM stage (default
// owner) and the UART loader. Loader bursts are capped at BURST_LEN beats;
// a loader blocked by MAX_WAIT cycles of CPU traffic gets one forced slot.
// Optional build macro ARB_STATS_EN adds stall/forced-slot counters.
module dmem_bus_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  dmem_bus_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       forced_slots
`endif
);

  localparam int unsigned WAIT_W = clog2_min1(MAX_WAIT);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;

  arb_state_e state_q, state_d;
  logic       cpu_act;
  logic       grant;
  logic       stall;
  logic       wait_clr, wait_inc, wait_term;
  logic       beat_clr, beat_inc, beat_term;

  assign cpu_act = bus.cpu_rd | bus.cpu_wr;
  assign grant   = (state_q != S_CPU);
  assign stall   = grant & cpu_act;

  arb_wait_counter #(.WIDTH(WAIT_W), .TERM(MAX_WAIT - 1)) u_wait_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (wait_clr),
    .inc_i  (wait_inc),
    .term_o (wait_term)
  );

  arb_wait_counter #(.WIDTH(BEAT_W), .TERM(BURST_LEN - 1)) u_beat_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (beat_clr),
    .inc_i  (beat_inc),
    .term_o (beat_term)
  );

  // Ownership state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_CPU;
    else        state_q <= state_d;
  end

  // Next ownership and counter control.
  always_comb begin
    state_d  = state_q;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    beat_clr = 1'b0;
    beat_inc = 1'b0;
    unique case (state_q)
      S_CPU: begin
        if (bus.ldr_req && !cpu_act) begin
          state_d  = S_LDR;
          wait_clr = 1'b1;
          beat_clr = 1'b1;
        end else if (bus.ldr_req) begin
          if (wait_term) state_d  = S_FORCE;
          else           wait_inc = 1'b1;
        end else begin
          wait_clr = 1'b1;
        end
      end
      S_LDR: begin
        if (!bus.ldr_req || beat_term) begin
          state_d  = S_CPU;
          beat_clr = 1'b1;
        end else begin
          beat_inc = 1'b1;
        end
      end
      S_FORCE: begin
        state_d  = S_CPU;
        wait_clr = 1'b1;
      end
      default: state_d = S_CPU;
    endcase
  end

  // Single-cycle memory: owner's request steers the port combinationally.
  always_comb begin
    bus.grant_ldr = grant;
    bus.cpu_stall = stall;
    bus.ldr_ack   = grant & bus.ldr_req;
    if (grant) begin
      bus.mem_rd    = bus.ldr_req & ~bus.ldr_we;
      bus.mem_wr    = bus.ldr_req & bus.ldr_we;
      bus.mem_addr  = bus.ldr_addr;
      bus.mem_wdata = bus.ldr_wdata;
      bus.ldr_rdata = bus.mem_rdata;
      bus.cpu_rdata = '0;
    end else begin
      bus.mem_rd    = bus.cpu_rd;
      bus.mem_wr    = bus.cpu_wr;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.ldr_rdata = '0;
      bus.cpu_rdata = bus.mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] forced_slots_q;

  // Saturating counters of stalled cycles and forced-slot entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      forced_slots_q <= '0;
    end else begin
      if (stall && stall_cycles_q != '1)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (state_q == S_CPU && state_d == S_FORCE && forced_slots_q != '1)
        forced_slots_q <= forced_slots_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign forced_slots = forced_slots_q;
`endif

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Shares the single data-memory/peripheral port between two requesters: the CPU MEM stage (default owner) and a UART program/data loader.
- Sits between the EX/MEM register outputs and the DataMem block.
- Asserts a stall back to the hazard logic while the loader owns the port.
- Guarantees loader progress through a starvation counter and bounds each loader burst.

Parameters:
- MAX_WAIT, 16: cycles the loader may be blocked by continuous CPU traffic before one slot is forced.
- BURST_LEN, 8: maximum loader beats per grant before the port returns to the CPU.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- cpu_rd  in  1  CPU MEM-stage read request
- cpu_wr  in  1  CPU MEM-stage write request
- cpu_addr  in  32  CPU address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data
- cpu_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- ldr_req  in  1  loader access request
- ldr_we  in  1  loader write enable (0 = read)
- ldr_addr  in  32  loader address
- ldr_wdata  in  32  loader write data
- ldr_ack  out  1  loader access performed this cycle
- ldr_rdata  out  32  loader read data
- mem_rd  out  1  to DataMem read
- mem_wr  out  1  to DataMem write
- mem_addr  out  32  to DataMem addr
- mem_wdata  out  32  to DataMem wdata
- mem_rdata  in  32  from DataMem rdata (combinational)
- grant_ldr  out  1  loader currently owns the port

Interface decision: one clock, clk; reset is asynchronous and active-low, port name reset.

Behaviour:
- cpu_act = cpu_rd | cpu_wr.
- States: S_CPU, S_LDR, S_FORCE. Registers: state, wait_cnt, beat_cnt.
- Reset values: state = S_CPU, wait_cnt = 0, beat_cnt = 0. All outputs then follow from S_CPU: cpu_stall = 0, ldr_ack = 0, grant_ldr = 0, and the mem_* outputs mirror the CPU inputs.
- Memory is single-cycle, so all data paths are combinational:
  - Owner's rd/wr/addr/wdata drive mem_*.
  - mem_rdata goes to the owner's rdata output; the non-owner's rdata output is 0.
  - ldr_ack = grant_ldr & ldr_req, same cycle; the write commits at that clock edge.
  - Loader handshake: hold ldr_req/addr/data until ldr_ack. The next beat may be presented in the following cycle.
- S_CPU:
  - CPU owns the port.
  - ldr_req & !cpu_act: go to S_LDR. beat_cnt = 0, wait_cnt = 0.
  - ldr_req & cpu_act:
    - If wait_cnt == MAX_WAIT-1, go to S_FORCE.
    - Otherwise wait_cnt++.
  - !ldr_req: wait_cnt = 0.
- S_LDR:
  - Loader owns the port. grant_ldr = 1. cpu_stall = cpu_act.
  - Each cycle with ldr_req is one beat; beat_cnt++.
  - Return to S_CPU (beat_cnt = 0) when either:
    - !ldr_req (no access is issued that cycle), or
    - the beat just issued was number BURST_LEN (beat_cnt == BURST_LEN-1).
- S_FORCE:
  - Exactly one loader beat. grant_ldr = 1. cpu_stall = cpu_act.
  - Next state S_CPU, wait_cnt = 0.
  - If ldr_req dropped on entry, no access is made and the state still returns to S_CPU.
- Stalled CPU requests are held by the pipeline freeze and replay when the CPU regains the port. No CPU access is ever dropped or duplicated.
- A CPU read and write asserted together pass through unmodified; DataMem resolves them.
- Counter widths: $clog2(MAX_WAIT) and $clog2(BURST_LEN)+1. No wrap is possible, since both counters clear at their limit.
- Reset mid-burst:
  - Immediate return to S_CPU.
  - A write coinciding with reset assertion is not guaranteed; the loader retries after reset.
- BURST_LEN = 1 degenerates S_LDR to single beats.

Optional Feature:
- ARB_STATS_EN, defined:
  - Adds outputs stall_cycles[31:0] and forced_slots[15:0]. Both reset to 0 and saturate at all-ones.
  - stall_cycles counts cycles with cpu_stall = 1.
  - forced_slots counts entries into S_FORCE.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - state enum {S_CPU, S_LDR, S_FORCE}
  - default MAX_WAIT/BURST_LEN constants
  - 32-bit address/data width constant
- One natural sub-module: arb_wait_counter, the parameterised clear/increment/terminal-count counter, instantiated for both wait_cnt and beat_cnt.

Test Plan:
- Reset held low with cpu_rd = 1, addr 0x40000010 -> cpu_stall = 0, grant_ldr = 0, mem_addr = 0x40000010 throughout; state S_CPU after release.
- CPU idle, loader writes 3 beats (0x100 ← 0xA5, 0x104 ← 0xB6, 0x108 ← 0xC7) then drops ldr_req -> ldr_ack high 3 cycles; read-back gives the same values; S_CPU the cycle after req drops.
- Loader holds req for 12 beats, BURST_LEN = 8, CPU idle -> 8 acks, one S_CPU cycle, then 4 more acks.
- CPU reads every cycle while loader requests, MAX_WAIT = 16 -> first ldr_ack on cycle 17; cpu_stall high exactly that one cycle; the CPU read replays with correct data.
- In S_LDR the CPU asserts cpu_wr 0x200 ← 0x1234 -> cpu_stall = 1 and mem_wr carries only the loader access; after return, 0x200 holds 0x1234, written once.
- Reset asserted during beat 2 of a burst -> grant_ldr = 0 and ldr_ack = 0 immediately; with ARB_STATS_EN, both counters read 0.
